// File: rtl/id_ex_stage_buf_pkg.sv
// Shared definitions for the ID/EX stage: default widths, EX-field bit positions,
// the all-zero control bubble and the default-width payload record.
package idex_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_PC_W    = 8;
    localparam int DEF_RA_W    = 5;
    localparam int DEF_M_W     = 3;
    localparam int DEF_WB_W    = 2;
    localparam int DEF_ALUOP_W = 2;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_EX_W    = DEF_ALUOP_W + 2;

    // EX field layout is {reg_dst, alu_op, alu_src}
    localparam int EX_ALU_SRC_BIT = 0;
    localparam int EX_ALU_OP_LSB  = 1;

    function automatic int ex_reg_dst_bit(input int aluop_w);
        return aluop_w + 1;
    endfunction

    localparam logic [DEF_M_W+DEF_WB_W+DEF_EX_W-1:0] CTRL_BUBBLE = '0;

    typedef struct packed {
        logic [DEF_PC_W-1:0]   pc;
        logic [DEF_DATA_W-1:0] rs_data;
        logic [DEF_DATA_W-1:0] rt_data;
        logic [DEF_DATA_W-1:0] imm;
        logic [DEF_RA_W-1:0]   rd;
        logic [DEF_RA_W-1:0]   rt;
        logic [DEF_M_W-1:0]    m;
        logic [DEF_WB_W-1:0]   wb;
        logic [DEF_EX_W-1:0]   ex;
    } idex_payload_t;

endpackage

// File: rtl/id_ex_stage_buf_if.sv
// Decode-side and EX-side handshake/payload bundle of the ID/EX stage.
interface id_ex_stage_buf_if
    import idex_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int PC_W    = DEF_PC_W,
    parameter int RA_W    = DEF_RA_W,
    parameter int M_W     = DEF_M_W,
    parameter int WB_W    = DEF_WB_W,
    parameter int ALUOP_W = DEF_ALUOP_W,
    parameter int CNT_W   = DEF_CNT_W
);
    localparam int EX_W = ALUOP_W + 2;

    logic               in_valid;
    logic               in_ready;
    logic               flush;
    logic [PC_W-1:0]    pc_in;
    logic [DATA_W-1:0]  rs_data_in;
    logic [DATA_W-1:0]  rt_data_in;
    logic [DATA_W-1:0]  imm_in;
    logic [RA_W-1:0]    rd_in;
    logic [RA_W-1:0]    rt_in;
    logic [M_W-1:0]     m_in;
    logic [WB_W-1:0]    wb_in;
    logic [EX_W-1:0]    ex_in;

    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    pc_out;
    logic [DATA_W-1:0]  rs_data_out;
    logic [DATA_W-1:0]  rt_data_out;
    logic [DATA_W-1:0]  imm_out;
    logic [RA_W-1:0]    rd_out;
    logic [RA_W-1:0]    rt_out;
    logic [M_W-1:0]     m_out;
    logic [WB_W-1:0]    wb_out;
    logic               reg_dst;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         occupancy;
    logic [CNT_W-1:0]   stall_cnt;

    modport master (
        output in_valid, flush, pc_in, rs_data_in, rt_data_in, imm_in, rd_in, rt_in,
               m_in, wb_in, ex_in, out_ready,
        input  in_ready, out_valid, pc_out, rs_data_out, rt_data_out, imm_out, rd_out,
               rt_out, m_out, wb_out, reg_dst, alu_src, alu_op, occupancy, stall_cnt
    );

    modport slave (
        input  in_valid, flush, pc_in, rs_data_in, rt_data_in, imm_in, rd_in, rt_in,
               m_in, wb_in, ex_in, out_ready,
        output in_ready, out_valid, pc_out, rs_data_out, rt_data_out, imm_out, rd_out,
               rt_out, m_out, wb_out, reg_dst, alu_src, alu_op, occupancy, stall_cnt
    );

endinterface

// File: rtl/id_ex_stage_buf_skid.sv
// Generic two-entry skid buffer: main entry drives the outputs, skid entry absorbs
// one extra beat so in_ready never depends combinationally on out_ready.
module idex_skid_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);
    logic         main_valid;
    logic         skid_valid;
    logic [W-1:0] main_data;
    logic [W-1:0] skid_data;
    logic         accept;
    logic         drain;

    assign in_ready  = ~skid_valid & ~rst;
    assign accept    = in_valid & in_ready;
    assign drain     = main_valid & out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    // Flush only invalidates; data registers keep their last contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (drain && skid_valid) begin
            main_valid <= 1'b1;
            main_data  <= skid_data;
            skid_valid <= 1'b0;
        end else if (!main_valid || drain) begin
            main_valid <= accept;
            if (accept) begin
                main_data <= in_data;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end

endmodule

// File: rtl/id_ex_stage_buf.sv
// ID/EX pipeline register with valid/ready handshake, skid buffering, flush,
// bubble insertion on the control fields and a saturating stall counter.
module id_ex_stage_buf
    import idex_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int PC_W    = DEF_PC_W,
    parameter int RA_W    = DEF_RA_W,
    parameter int M_W     = DEF_M_W,
    parameter int WB_W    = DEF_WB_W,
    parameter int ALUOP_W = DEF_ALUOP_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input logic              clk_IDEX,
    input logic              rst_IDEX,
    id_ex_stage_buf_if.slave bus
);
    localparam int EX_W   = ALUOP_W + 2;
    localparam int RD_BIT = ex_reg_dst_bit(ALUOP_W);
    localparam int PAY_W  = PC_W + 3*DATA_W + 2*RA_W + M_W + WB_W + EX_W;

    logic [PAY_W-1:0]  pay_in;
    logic [PAY_W-1:0]  pay_out;
    logic              main_valid;
    logic [PC_W-1:0]   pc_q;
    logic [DATA_W-1:0] rs_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [DATA_W-1:0] imm_q;
    logic [RA_W-1:0]   rd_q;
    logic [RA_W-1:0]   rt_q;
    logic [M_W-1:0]    m_q;
    logic [WB_W-1:0]   wb_q;
    logic [EX_W-1:0]   ex_q;
    logic [CNT_W-1:0]  stall_q;

    assign pay_in = {bus.pc_in, bus.rs_data_in, bus.rt_data_in, bus.imm_in,
                     bus.rd_in, bus.rt_in, bus.m_in, bus.wb_in, bus.ex_in};

    idex_skid_reg #(.W(PAY_W)) u_skid (
        .clk       (clk_IDEX),
        .rst       (rst_IDEX),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (pay_in),
        .out_valid (main_valid),
        .out_ready (bus.out_ready),
        .out_data  (pay_out),
        .occupancy (bus.occupancy)
    );

    assign {pc_q, rs_q, rt_data_q, imm_q, rd_q, rt_q, m_q, wb_q, ex_q} = pay_out;

    assign bus.out_valid   = main_valid;
    assign bus.pc_out      = pc_q;
    assign bus.rs_data_out = rs_q;
    assign bus.rt_data_out = rt_data_q;
    assign bus.imm_out     = imm_q;
    assign bus.rd_out      = rd_q;
    assign bus.rt_out      = rt_q;

    // An empty stage must look like a nop to MEM/WB, so control is gated by valid.
    assign bus.m_out   = main_valid ? m_q  : '0;
    assign bus.wb_out  = main_valid ? wb_q : '0;
    assign bus.reg_dst = main_valid & ex_q[RD_BIT];
    assign bus.alu_src = main_valid & ex_q[EX_ALU_SRC_BIT];
    assign bus.alu_op  = main_valid ? ex_q[EX_ALU_OP_LSB +: ALUOP_W] : '0;

    always_ff @(posedge clk_IDEX) begin
        if (rst_IDEX) begin
            stall_q <= '0;
        end else if (main_valid && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_id_ex_stage_buf.sv
// Directed bench for id_ex_stage_buf with a queue-based scoreboard and an independent output monitor.
module tb_id_ex_stage_buf;
    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rt;
        logic [2:0]  m;
        logic [1:0]  wb;
        logic        reg_dst;
        logic [1:0]  alu_op;
        logic        alu_src;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t exp_q[$];
    exp_t pending;

    id_ex_stage_buf_if bus ();

    id_ex_stage_buf dut (
        .clk_IDEX (clk),
        .rst_IDEX (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("[TB] FAIL %s got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic apply_stimulus(input exp_t e, input logic [3:0] ex);
        bus.pc_in      = e.pc;
        bus.rs_data_in = e.rs_data;
        bus.rt_data_in = e.rt_data;
        bus.imm_in     = e.imm;
        bus.rd_in      = e.rd;
        bus.rt_in      = e.rt;
        bus.m_in       = e.m;
        bus.wb_in      = e.wb;
        bus.ex_in      = ex;
        bus.in_valid   = 1'b1;
        pending        = e;
        tick();
    endtask

    task automatic go_idle();
        bus.in_valid = 1'b0;
    endtask

    // Predictor: every accepted beat is pushed; flush or reset empties the expectation.
    always @(negedge clk) begin
        if (rst || bus.flush) begin
            exp_q.delete();
        end else if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(pending);
        end
    end

    // Monitor: each beat EX takes is compared against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        exp_t act;
        if (!rst && !bus.flush && bus.out_valid && bus.out_ready) begin
            act = '{bus.pc_out, bus.rs_data_out, bus.rt_data_out, bus.imm_out, bus.rd_out,
                    bus.rt_out, bus.m_out, bus.wb_out, bus.reg_dst, bus.alu_op, bus.alu_src};
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL monitor_unexpected got %h expected nothing", act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    tests_failed++;
                    $display("[TB] FAIL monitor_beat got %h expected %h", act, e);
                end
            end
        end
    end

    initial begin
        exp_t a, b, c, d, ev, f, g, h;
        exp_t v[4];

        bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
        bus.pc_in = '0; bus.rs_data_in = '0; bus.rt_data_in = '0; bus.imm_in = '0;
        bus.rd_in = '0; bus.rt_in = '0; bus.m_in = '0; bus.wb_in = '0; bus.ex_in = '0;
        pending = '0;

        // Reset behaviour
        tick();
        check_output("rst_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        tick();
        check_output("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_output("rst_occupancy", 64'(bus.occupancy), 64'd0);
        check_output("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
        check_output("rst_rs_data", 64'(bus.rs_data_out), 64'd0);
        check_output("rst_pc", 64'(bus.pc_out), 64'd0);
        check_output("rst_ctrl", 64'({bus.m_out, bus.wb_out, bus.reg_dst, bus.alu_op, bus.alu_src}), 64'd0);
        rst = 1'b0;
        #1;
        check_output("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Streaming with EX always ready
        v[0] = '{8'h04, 32'd1, 32'h100, 32'hFFFF_FFF0, 5'd1, 5'd2, 3'b001, 2'b10, 1'b1, 2'b10, 1'b0};
        v[1] = '{8'h08, 32'd2, 32'h200, 32'h0000_0010, 5'd3, 5'd4, 3'b010, 2'b01, 1'b0, 2'b00, 1'b1};
        v[2] = '{8'h0C, 32'd3, 32'h300, 32'h0000_7FFF, 5'd5, 5'd6, 3'b100, 2'b11, 1'b0, 2'b01, 1'b1};
        v[3] = '{8'h10, 32'd4, 32'h400, 32'h8000_0000, 5'd7, 5'd8, 3'b000, 2'b00, 1'b1, 2'b11, 1'b1};
        bus.out_ready = 1'b1;
        apply_stimulus(v[0], 4'b1100);
        check_output("stream_latency", 64'(bus.out_valid), 64'd1);
        apply_stimulus(v[1], 4'b0001);
        check_output("stream_occ1", 64'(bus.occupancy), 64'd1);
        apply_stimulus(v[2], 4'b0011);
        apply_stimulus(v[3], 4'b1111);
        check_output("stream_occ3", 64'(bus.occupancy), 64'd1);
        go_idle();
        tick();
        tick();
        check_output("stream_empty", 64'(bus.out_valid), 64'd0);
        check_output("bubble_ctrl", 64'({bus.m_out, bus.wb_out, bus.reg_dst, bus.alu_op, bus.alu_src}), 64'd0);
        check_output("bubble_data_hold", 64'(bus.rs_data_out), 64'd4);

        // Back-pressure fills the skid entry
        a = '{8'h20, 32'hAAAA_0001, 32'd11, 32'd12, 5'd9,  5'd10, 3'b011, 2'b01, 1'b0, 2'b01, 1'b0};
        b = '{8'h24, 32'hBBBB_0002, 32'd21, 32'd22, 5'd11, 5'd12, 3'b110, 2'b10, 1'b1, 2'b00, 1'b0};
        bus.out_ready = 1'b0;
        apply_stimulus(a, 4'b0010);
        check_output("bp_occ1", 64'(bus.occupancy), 64'd1);
        apply_stimulus(b, 4'b1000);
        check_output("bp_occ2", 64'(bus.occupancy), 64'd2);
        check_output("bp_in_ready", 64'(bus.in_ready), 64'd0);
        go_idle();
        repeat (3) tick();
        check_output("bp_stall_cnt", 64'(bus.stall_cnt), 64'd4);
        check_output("bp_head", 64'(bus.rs_data_out), 64'hAAAA_0001);
        bus.out_ready = 1'b1;
        tick();
        check_output("bp_drain1_occ", 64'(bus.occupancy), 64'd1);
        check_output("bp_drain1_ready", 64'(bus.in_ready), 64'd1);
        tick();
        check_output("bp_drain2_occ", 64'(bus.occupancy), 64'd0);
        check_output("bp_stall_hold", 64'(bus.stall_cnt), 64'd4);

        // Flush with two entries held
        c = '{8'h30, 32'hCCCC_0003, 32'd31, 32'd32, 5'd13, 5'd14, 3'b101, 2'b11, 1'b1, 2'b10, 1'b1};
        d = '{8'h34, 32'hDDDD_0004, 32'd41, 32'd42, 5'd15, 5'd16, 3'b001, 2'b01, 1'b0, 2'b01, 1'b0};
        bus.out_ready = 1'b0;
        apply_stimulus(c, 4'b1101);
        check_output("ex_decode", 64'({bus.reg_dst, bus.alu_op, bus.alu_src}), 64'b1101);
        check_output("wb_m_pass", 64'({bus.m_out, bus.wb_out}), 64'b10111);
        apply_stimulus(d, 4'b0010);
        check_output("flush_pre_occ", 64'(bus.occupancy), 64'd2);
        go_idle();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check_output("flush_valid", 64'(bus.out_valid), 64'd0);
        check_output("flush_ctrl", 64'({bus.m_out, bus.wb_out, bus.reg_dst, bus.alu_op, bus.alu_src}), 64'd0);
        check_output("flush_occ", 64'(bus.occupancy), 64'd0);
        check_output("flush_in_ready", 64'(bus.in_ready), 64'd1);
        check_output("flush_stall_kept", 64'(bus.stall_cnt), 64'd6);
        check_output("flush_data_hold", 64'(bus.rs_data_out), 64'hCCCC_0003);

        // Flush beats a same-cycle input
        ev = '{8'h40, 32'hEEEE_0005, 32'd51, 32'd52, 5'd17, 5'd18, 3'b111, 2'b11, 1'b1, 2'b11, 1'b1};
        f  = '{8'h44, 32'hFFFF_0006, 32'd61, 32'd62, 5'd19, 5'd20, 3'b010, 2'b10, 1'b0, 2'b10, 1'b0};
        bus.out_ready = 1'b1;
        bus.flush = 1'b1;
        apply_stimulus(ev, 4'b1111);
        bus.flush = 1'b0;
        go_idle();
        check_output("flush_in_valid", 64'(bus.out_valid), 64'd0);
        check_output("flush_in_occ", 64'(bus.occupancy), 64'd0);
        tick();
        check_output("flush_in_later", 64'(bus.out_valid), 64'd0);
        apply_stimulus(f, 4'b0100);
        go_idle();
        tick();
        tick();

        // Stall counter saturation
        g = '{8'h50, 32'h1234_5678, 32'd71, 32'd72, 5'd21, 5'd22, 3'b100, 2'b01, 1'b0, 2'b11, 1'b0};
        h = '{8'h54, 32'h8765_4321, 32'd81, 32'd82, 5'd23, 5'd24, 3'b001, 2'b10, 1'b1, 2'b00, 1'b1};
        bus.out_ready = 1'b0;
        apply_stimulus(g, 4'b0110);
        go_idle();
        repeat (70000) tick();
        check_output("stall_saturate", 64'(bus.stall_cnt), 64'd65535);
        check_output("stall_head", 64'(bus.rs_data_out), 64'h1234_5678);

        // Reset in the middle of traffic discards both entries
        apply_stimulus(h, 4'b1001);
        go_idle();
        check_output("mid_occ2", 64'(bus.occupancy), 64'd2);
        rst = 1'b1;
        tick();
        check_output("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check_output("mid_rst_occ", 64'(bus.occupancy), 64'd0);
        check_output("mid_rst_stall", 64'(bus.stall_cnt), 64'd0);
        check_output("mid_rst_data", 64'(bus.rs_data_out), 64'd0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check_output("mid_rst_after", 64'(bus.out_valid), 64'd0);
        check_output("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
